reaction_ctrl: RTL and testbench
================================

Name: reaction_ctrl

Overview:
Game controller for the reaction-time tester.
- Consumes the level output of the millisecond timer (`max_reached`) on `ms_tick` and drives that timer's `reset`/`enable` pins.
- Waits a pseudo-random delay, lights the stimulus LED, then counts milliseconds in 4-digit BCD until the player presses the button.
- Flags a false start if the button is pressed before the LED lights.
- Sits between the button input / timer instance and the 7-segment display driver.

Parameters:
- DELAY_MIN_TICKS, 1000, minimum wait before the LED lights, in timer ticks.
- DELAY_RANGE_BITS, 11, width of the random addend; wait = DELAY_MIN_TICKS + lfsr[DELAY_RANGE_BITS-1:0].
- LFSR_SEED, 16'hACE1, reset value of the LFSR; must be nonzero.

Ports:
- clk  input  1  system clock (20 MHz).
- reset  input  1  synchronous, active-low reset; one clock domain.
- button  input  1  raw pushbutton, active-high, asynchronous to clk.
- ms_tick  input  1  level from the timer's `max_reached`; a rising edge marks one tick.
- timer_reset  output  1  active-low reset to the timer.
- timer_enable  output  1  enable to the timer.
- led_on  output  1  stimulus LED.
- bcd  output  16  reaction time; 4 BCD digits, [15:12] = thousands.
- result_valid  output  1  high while a valid result is held.
- false_start  output  1  high while a false start is displayed.

Behaviour:
- **Reset (reset=0 at a clk edge):**
  - state=IDLE, bcd=0, led_on=0, result_valid=0, false_start=0, timer_enable=0, timer_reset=0.
  - lfsr=LFSR_SEED; sync flops and edge registers cleared.
  - Reset mid-round aborts the round with no residue.
- **Button path:**
  - 2-flop synchronizer, then a rising-edge detector.
  - A `press` pulse is 1 cycle wide and asserted 2 cycles after button is first sampled high.
  - A held button generates no further presses.
- **Tick path:** `tick_rise` = ms_tick & ~ms_tick_d (registered copy of ms_tick). Required because the timer holds `max_reached` high for about CLKS_PER_MS cycles.
- **LFSR:**
  - 16-bit Fibonacci, taps 16,14,13,11, advances every cycle in every state.
  - Never reaches 0.
- **delay_cnt:**
  - 16-bit.
  - Requirement: DELAY_MIN_TICKS + 2^DELAY_RANGE_BITS - 1 <= 65535.
  - Sum computed at 16 bits, no truncation.
- **IDLE:**
  - timer_reset=0, timer_enable=0.
  - On press: load delay_cnt, clear bcd, result_valid and false_start, go to WAIT.
- **WAIT:**
  - timer_reset=1, timer_enable=1.
  - On tick_rise: if delay_cnt==1, go to ARMED; else decrement delay_cnt.
  - On press: go to FALSE_START. Press wins over a simultaneous tick_rise.
- **ARMED:**
  - led_on=1, timer_enable=1.
  - timer_reset=0 for exactly the first cycle in ARMED (timer realign), then 1.
  - Each tick_rise increments bcd with decimal carry.
  - bcd saturates at 9999 and stays in ARMED until press.
  - On press: go to RESULT. If press and tick_rise occur in the same cycle, the increment is applied before freezing.
- **RESULT:**
  - led_on=0, timer_enable=0, timer_reset=0, result_valid=1, bcd held.
  - On press: start a new round exactly as from IDLE (go to WAIT).
- **FALSE_START:**
  - false_start=1, bcd=0, led_on=0, timer_enable=0, timer_reset=0.
  - On press: new round (go to WAIT).
- **Output timing:** all outputs registered or decoded from registered state; no combinational path from button or ms_tick to any output.
- **Invariant:** result_valid and false_start are never both 1.

Decomposition:
- Package `reaction_pkg`:
  - state enum: IDLE, WAIT, ARMED, RESULT, FALSE_START.
  - BCD_MAX = 16'h9999.
  - LFSR tap mask.
- Sub-module `bcd_counter4`:
  - Ports: clk, reset, clr, inc, q[15:0].
  - Saturating 4-digit BCD incrementer.
  - clr has priority over inc.

Test Plan (DELAY_MIN_TICKS=4, DELAY_RANGE_BITS=2; ms_tick driven by the bench as 3-cycle high pulses):
1. **Reset values:** reset low 2 cycles → every output 0, timer_reset=0. Release → still IDLE, outputs unchanged.
2. **Normal round:**
   - Press, then tick pulses → led_on rises after exactly 4+lfsr[1:0] tick_rises.
   - timer_reset low exactly 1 cycle at ARMED entry.
   - 37 further ticks, then press → bcd=16'h0037, result_valid=1, led_on=0.
3. **False start:** press, 2 ticks, press → false_start=1, bcd=0, led_on never asserted, timer_enable=0.
4. **Simultaneous events:**
   - In ARMED, press synchronized to land on the same cycle as a tick_rise → bcd includes that tick.
   - Same alignment in WAIT → FALSE_START, not ARMED.
5. **Carry and saturation:**
   - Force bcd to 0999, one tick → 1000.
   - 0099 → 0100.
   - From 9998, 3 ticks → 9999 held, state stays ARMED until press.
6. **Level vs edge and mid-round reset:**
   - ms_tick held high 50 cycles counts as 1 tick; held button gives 1 press.
   - reset asserted in ARMED → IDLE, bcd=0 next cycle.

Source files
------------

// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-time tester controller.
package reaction_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    ARMED,
    RESULT,
    FALSE_START
  } state_t;

  localparam logic [15:0] BCD_MAX   = 16'h9999;

  // Feedback taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // One Fibonacci step: shift left, feed back the XOR of the tapped bits.
  function automatic logic [15:0] lfsr_next(input logic [15:0] q);
    return {q[14:0], ^(q & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/bcd_counter4.sv
// Four-digit BCD up-counter that sticks at 9999; clear beats increment.
module bcd_counter4
  import reaction_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] q
);

  // Decimal increment with ripple carry across digits; 9999 maps to itself.
  function automatic logic [15:0] bcd_inc_sat(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    if (v != BCD_MAX) begin
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (v[i*4 +: 4] == 4'd9) begin
            r[i*4 +: 4] = 4'd0;
          end else begin
            r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  // Count register: reset and clr zero it, inc steps it by one decimal count.
  always_ff @(posedge clk) begin
    if (!reset) begin
      q <= 16'h0000;
    end else if (clr) begin
      q <= 16'h0000;
    end else if (inc) begin
      q <= bcd_inc_sat(q);
    end
  end

endmodule

// File: rtl/reaction_ctrl.sv
// Reaction-time game controller: random wait, stimulus LED, BCD ms count,
// false-start detection. Drives the millisecond timer's reset/enable.
module reaction_ctrl
  import reaction_pkg::*;
#(
  parameter int          DELAY_MIN_TICKS  = 1000,
  parameter int          DELAY_RANGE_BITS = 11,
  parameter logic [15:0] LFSR_SEED        = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        button,
  input  logic        ms_tick,
  output logic        timer_reset,
  output logic        timer_enable,
  output logic        led_on,
  output logic [15:0] bcd,
  output logic        result_valid,
  output logic        false_start
);

  localparam logic [15:0] DELAY_MIN = 16'(DELAY_MIN_TICKS);

  state_t      state;
  logic [15:0] lfsr;
  logic [15:0] delay_cnt;
  logic [15:0] delay_load;
  logic        btn_p0;
  logic        btn_p1;
  logic        btn_p2;
  logic        ms_tick_d;
  logic        press;
  logic        tick_rise;
  logic        bcd_clr;
  logic        bcd_inc;

  // Button: two synchronizer flops, third flop is the edge-detect history.
  // ms_tick is already in the clk domain; its registered copy finds the rise.
  // The LFSR free-runs every cycle so the round delay depends on press timing.
  always_ff @(posedge clk) begin
    if (!reset) begin
      btn_p0    <= 1'b0;
      btn_p1    <= 1'b0;
      btn_p2    <= 1'b0;
      ms_tick_d <= 1'b0;
      lfsr      <= LFSR_SEED;
    end else begin
      btn_p0    <= button;
      btn_p1    <= btn_p0;
      btn_p2    <= btn_p1;
      ms_tick_d <= ms_tick;
      lfsr      <= lfsr_next(lfsr);
    end
  end

  assign press      = btn_p1 & ~btn_p2;
  assign tick_rise  = ms_tick & ~ms_tick_d;
  assign delay_load = DELAY_MIN + 16'(lfsr[DELAY_RANGE_BITS-1:0]);

  // Any press outside ARMED begins a new round or a false start: both show 0.
  assign bcd_clr = press && (state != ARMED);
  // In ARMED a tick coinciding with the stopping press is still counted.
  assign bcd_inc = (state == ARMED) && tick_rise;

  bcd_counter4 u_bcd (
    .clk   (clk),
    .reset (reset),
    .clr   (bcd_clr),
    .inc   (bcd_inc),
    .q     (bcd)
  );

  // Round FSM; outputs are registered on state entry so nothing combinational
  // from button or ms_tick reaches a pin.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      delay_cnt    <= 16'd0;
      led_on       <= 1'b0;
      timer_enable <= 1'b0;
      timer_reset  <= 1'b0;
      result_valid <= 1'b0;
      false_start  <= 1'b0;
    end else begin
      case (state)
        IDLE, RESULT, FALSE_START: begin
          if (press) begin
            state        <= WAIT;
            delay_cnt    <= delay_load;
            led_on       <= 1'b0;
            timer_enable <= 1'b1;
            timer_reset  <= 1'b1;
            result_valid <= 1'b0;
            false_start  <= 1'b0;
          end
        end
        WAIT: begin
          if (press) begin
            state        <= FALSE_START;
            timer_enable <= 1'b0;
            timer_reset  <= 1'b0;
            false_start  <= 1'b1;
          end else if (tick_rise) begin
            if (delay_cnt == 16'd1) begin
              state       <= ARMED;
              led_on      <= 1'b1;
              // Hold the timer in reset for one cycle so ms ticks start
              // aligned with the LED.
              timer_reset <= 1'b0;
            end else begin
              delay_cnt <= delay_cnt - 16'd1;
            end
          end
        end
        ARMED: begin
          if (press) begin
            state        <= RESULT;
            led_on       <= 1'b0;
            timer_enable <= 1'b0;
            timer_reset  <= 1'b0;
            result_valid <= 1'b1;
          end else begin
            timer_reset <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reaction_ctrl.sv
// Randomized self-checking bench for reaction_ctrl against a behavioural model.
`timescale 1ns/1ps
module tb_reaction_ctrl;

  localparam int DMIN = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        button;
  logic        ms_tick;
  logic        timer_reset;
  logic        timer_enable;
  logic        led_on;
  logic [15:0] bcd;
  logic        result_valid;
  logic        false_start;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural LFSR reference and running observation counters.
  logic [15:0] m_lfsr = 16'hACE1;
  int          led_cycles  = 0;
  int          trst_armed  = 0;
  int          excl_viol   = 0;
  int          led_snap;
  int          trst_snap;

  reaction_ctrl #(
    .DELAY_MIN_TICKS  (DMIN),
    .DELAY_RANGE_BITS (2),
    .LFSR_SEED        (16'hACE1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .button       (button),
    .ms_tick      (ms_tick),
    .timer_reset  (timer_reset),
    .timer_enable (timer_enable),
    .led_on       (led_on),
    .bcd          (bcd),
    .result_valid (result_valid),
    .false_start  (false_start)
  );

  always #25 clk = ~clk;

  always @(posedge clk) begin
    if (!reset) m_lfsr <= 16'hACE1;
    else        m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  always @(negedge clk) begin
    if (led_on) led_cycles <= led_cycles + 1;
    if (led_on && !timer_reset) trst_armed <= trst_armed + 1;
    if (result_valid && false_start) excl_viol <= excl_viol + 1;
  end

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int n);
    int v;
    v = (n > 9999) ? 9999 : n;
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Press: button high from a negedge; the controller acts on it at the third
  // following posedge, using the LFSR value present just before that edge.
  task automatic do_press(output logic [15:0] lf);
    @(negedge clk) button = 1'b1;
    @(negedge clk);
    @(negedge clk) lf = m_lfsr;
    @(negedge clk) button = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic tick(input int w, input int g);
    @(negedge clk) ms_tick = 1'b1;
    repeat (w) @(negedge clk);
    ms_tick = 1'b0;
    repeat (g) @(negedge clk);
  endtask

  // Press and tick rise land on the same clock edge.
  task automatic press_with_tick();
    @(negedge clk) button = 1'b1;
    @(negedge clk);
    @(negedge clk) ms_tick = 1'b1;
    repeat (3) @(negedge clk);
    ms_tick = 1'b0;
    button  = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic start_round(output int dly);
    logic [15:0] lf;
    led_snap  = led_cycles;
    trst_snap = trst_armed;
    do_press(lf);
    dly = DMIN + int'(lf[1:0]);
    check_eq("wait_enable", timer_enable, 1);
    check_eq("wait_treset", timer_reset, 1);
    check_eq("wait_bcd", bcd, 0);
    check_eq("wait_flags", {led_on, result_valid, false_start}, 0);
  endtask

  task automatic run_to_armed(input int dly);
    for (int i = 0; i < dly - 1; i++) tick(3, 1);
    check_eq("led_before_delay", led_on, 0);
    tick(3, 1);
    check_eq("led_at_delay", led_on, 1);
    check_eq("armed_enable", timer_enable, 1);
    check_eq("armed_treset", timer_reset, 1);
  endtask

  task automatic finish_result(input int n);
    logic [15:0] lf;
    do_press(lf);
    check_eq("result_bcd", bcd, to_bcd(n));
    check_eq("result_valid", result_valid, 1);
    check_eq("result_led_fs", {led_on, false_start, timer_enable}, 0);
    check_eq("treset_low_cycles", trst_armed - trst_snap, 1);
  endtask

  task automatic check_false_start();
    check_eq("fs_flag", false_start, 1);
    check_eq("fs_bcd", bcd, 0);
    check_eq("fs_outputs", {led_on, result_valid, timer_enable, timer_reset}, 0);
    check_eq("fs_led_never", led_cycles - led_snap, 0);
  endtask

  initial begin
    int          dly;
    int          n;
    int          k;
    logic [15:0] lf;

    reset = 1'b0; button = 1'b0; ms_tick = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_bcd", bcd, 0);
    check_eq("rst_outputs", {timer_reset, timer_enable, led_on, result_valid, false_start}, 0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("idle_bcd", bcd, 0);
    check_eq("idle_outputs", {timer_reset, timer_enable, led_on, result_valid, false_start}, 0);

    // Normal round: 37 counted ticks.
    start_round(dly);
    run_to_armed(dly);
    for (int i = 0; i < 37; i++) tick(3, 1);
    finish_result(37);

    // False start after two ticks.
    start_round(dly);
    tick(3, 1); tick(3, 1);
    do_press(lf);
    check_false_start();

    // Press coinciding with a tick in ARMED counts that tick.
    start_round(dly);
    run_to_armed(dly);
    for (int i = 0; i < 5; i++) tick(3, 1);
    press_with_tick();
    check_eq("simul_armed_bcd", bcd, to_bcd(6));
    check_eq("simul_armed_valid", result_valid, 1);

    // Press coinciding with the final delay tick is a false start.
    start_round(dly);
    for (int i = 0; i < dly - 1; i++) tick(3, 1);
    press_with_tick();
    check_false_start();

    // Long ms_tick level counts once.
    start_round(dly);
    run_to_armed(dly);
    tick(50, 2);
    finish_result(1);

    // Held button from RESULT gives exactly one press: round starts, no false start.
    @(negedge clk) button = 1'b1;
    repeat (50) @(negedge clk);
    button = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("held_btn_fs", false_start, 0);
    check_eq("held_btn_wait", {timer_enable, timer_reset, result_valid}, 3'b110);
    led_snap = led_cycles;
    do_press(lf);
    check_false_start();

    // Randomized rounds.
    for (int r = 0; r < 8; r++) begin
      start_round(dly);
      if ($urandom_range(0, 2) == 0) begin
        k = $urandom_range(0, dly - 1);
        for (int j = 0; j < k; j++) tick($urandom_range(1, 4), $urandom_range(1, 3));
        do_press(lf);
        check_false_start();
      end else begin
        run_to_armed(dly);
        n = $urandom_range(0, 60);
        for (int j = 0; j < n; j++) tick($urandom_range(1, 4), $urandom_range(1, 3));
        finish_result(n);
      end
    end

    // Decimal carries and saturation.
    start_round(dly);
    run_to_armed(dly);
    for (int i = 1; i <= 10001; i++) begin
      tick(3, 1);
      if (i == 99 || i == 100 || i == 999 || i == 1000 || i == 9998 ||
          i == 9999 || i == 10001)
        check_eq($sformatf("count_%0d", i), bcd, to_bcd(i));
    end
    check_eq("sat_still_armed", led_on, 1);
    finish_result(10001);

    // Reset in the middle of ARMED aborts the round.
    start_round(dly);
    run_to_armed(dly);
    for (int i = 0; i < 3; i++) tick(3, 1);
    @(negedge clk) reset = 1'b0;
    @(negedge clk);
    check_eq("midrst_bcd", bcd, 0);
    check_eq("midrst_outputs", {timer_reset, timer_enable, led_on, result_valid, false_start}, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    start_round(dly);
    run_to_armed(dly);
    tick(3, 1); tick(3, 1);
    finish_result(2);

    check_eq("valid_fs_exclusive", excl_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
